// File: rtl/load_store_unit.sv
// Memory-access stage between the execute ALU and writeback: alignment checks,
// store lane steering, a single-outstanding valid/ready request and load extension.
`timescale 1ns/1ps
module load_store_unit #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_func3,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  input  logic [4:0]        req_rd,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_wstrb,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic              mem_resp_valid,
  input  logic [DWIDTH-1:0] mem_resp_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [DWIDTH-1:0] wb_data,
  output logic              fault
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, FAULT} state_e;

  state_e            state_q, state_d;
  logic              is_store_q, is_store_d;
  logic [2:0]        func3_q, func3_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [4:0]        rd_q, rd_d;
  logic [DWIDTH-1:0] wb_data_q, wb_data_d;

  logic              req_fault;
  logic [1:0]        off;
  logic [3:0]        strb;
  logic [DWIDTH-1:0] steered;
  logic [DWIDTH-1:0] lane;
  logic [DWIDTH-1:0] extracted;

  assign off = addr_q[1:0];

  // Fault decode works on the live request so the FAULT state can be entered directly.
  always_comb begin
    req_fault = 1'b0;
    unique case (req_func3)
      3'b000:  req_fault = 1'b0;
      3'b001:  req_fault = req_addr[0];
      3'b010:  req_fault = (req_addr[1:0] != 2'b00);
      3'b100:  req_fault = req_is_store;
      3'b101:  req_fault = req_is_store | req_addr[0];
      default: req_fault = 1'b1;
    endcase
  end

  always_comb begin
    strb    = 4'b1111;
    steered = wdata_q;
    unique case (func3_q[1:0])
      2'b00: begin
        strb    = 4'b0001 << off;
        steered = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        strb    = off[1] ? 4'b1100 : 4'b0011;
        steered = {2{wdata_q[15:0]}};
      end
      default: begin
        strb    = 4'b1111;
        steered = wdata_q;
      end
    endcase
  end

  always_comb begin
    lane      = mem_resp_rdata >> {off, 3'b000};
    extracted = lane;
    unique case (func3_q)
      3'b000:  extracted = {{(DWIDTH-8){lane[7]}}, lane[7:0]};
      3'b001:  extracted = {{(DWIDTH-16){lane[15]}}, lane[15:0]};
      3'b100:  extracted = {{(DWIDTH-8){1'b0}}, lane[7:0]};
      3'b101:  extracted = {{(DWIDTH-16){1'b0}}, lane[15:0]};
      default: extracted = lane;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      is_store_q <= 1'b0;
      func3_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      func3_q    <= func3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    func3_d    = func3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    wb_data_d  = wb_data_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          is_store_d = req_is_store;
          func3_d    = req_func3;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          rd_d       = req_rd;
          state_d    = req_fault ? FAULT : ISSUE;
        end
      end
      ISSUE: begin
        if (mem_req_ready) state_d = is_store_q ? IDLE : WAIT;
      end
      WAIT: begin
        if (mem_resp_valid) begin
          wb_data_d = extracted;
          state_d   = RESP;
        end
      end
      RESP:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready     = (state_q == IDLE);
    mem_req_valid = (state_q == ISSUE);
    mem_we        = (state_q == ISSUE) & is_store_q;
    mem_wstrb     = ((state_q == ISSUE) & is_store_q) ? strb : 4'b0000;
    mem_addr      = {addr_q[AWIDTH-1:2], 2'b00};
    mem_wdata     = steered;
    wb_valid      = (state_q == RESP);
    wb_rd         = rd_q;
    wb_data       = wb_data_q;
    fault         = (state_q == FAULT);
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected memory requests, writebacks and
// faults are queued as stimulus is driven and checked when the DUT produces them.
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_func3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_rdata = '0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        fault;

  always #5 clk = ~clk;

  load_store_unit #(.DWIDTH(32), .AWIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .fault(fault)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_exp_t;

  mem_exp_t q_mem[$];
  wb_exp_t  q_wb[$];
  int       fault_exp = 0;
  int       n_tests = 0;
  int       n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic f_fault(input logic st, input logic [2:0] f3, input logic [31:0] a);
    if (st && f3 > 3'd2) return 1'b1;
    if (!st && (f3 == 3'b011 || f3 >= 3'b110)) return 1'b1;
    if (f3[1:0] == 2'b01 && a[0]) return 1'b1;
    if (f3[1:0] == 2'b10 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  // Byte-by-byte reference for store strobes and lane data.
  function automatic mem_exp_t f_mem(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] rs2);
    mem_exp_t   e;
    int         n;
    int         o;
    n = 1 << f3[1:0];
    o = int'(a[1:0]);
    e.addr  = {a[31:2], 2'b00};
    e.we    = st;
    e.strb  = '0;
    e.wdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (st && i >= o && i < o + n) e.strb[i] = 1'b1;
      e.wdata[8*i +: 8] = rs2[8*(i % n) +: 8];
    end
    if (!st) e.wdata = 'x;
    return e;
  endfunction

  function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rdata);
    logic [31:0] v;
    int          n;
    int          o;
    n = 1 << f3[1:0];
    o = int'(a[1:0]);
    v = '0;
    for (int j = 0; j < n; j++) v[8*j +: 8] = rdata[8*(o+j) +: 8];
    if (!f3[2] && n < 4 && v[8*n-1]) begin
      for (int k = 8*n; k < 32; k++) v[k] = 1'b1;
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req_valid && mem_req_ready) begin
        if (q_mem.size() == 0) chk("mem_unexpected", 1, 0);
        else begin
          mem_exp_t e;
          e = q_mem.pop_front();
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_we", mem_we, e.we);
          chk("mem_wstrb", mem_wstrb, e.strb);
          if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
        end
      end
      if (wb_valid) begin
        if (q_wb.size() == 0) chk("wb_unexpected", 1, 0);
        else begin
          wb_exp_t w;
          w = q_wb.pop_front();
          chk("wb_rd", wb_rd, w.rd);
          chk("wb_data", wb_data, w.data);
        end
      end
      if (fault) begin
        chk("fault_expected", fault_exp > 0, 1);
        if (fault_exp > 0) fault_exp--;
      end
      if (wb_valid && fault) chk("wb_fault_excl", 1, 0);
    end
  end

  // Called just after a rising edge; returns just after a rising edge with the unit idle.
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] rs2, input logic [4:0] rd, input logic [31:0] rdata,
                        input int unsigned rdy_dly, input int unsigned resp_dly);
    mem_exp_t e;
    wb_exp_t  w;
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_is_store = st; req_func3 = f3;
    req_addr = a; req_wdata = rs2; req_rd = rd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (f_fault(st, f3, a)) begin
      fault_exp++;
      @(negedge clk);
      chk("fault_no_memreq", mem_req_valid, 0);
      chk("fault_busy", req_ready, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("fault_ready_t2", req_ready, 1);
      chk("fault_no_memreq2", mem_req_valid, 0);
      @(posedge clk); #1;
      return;
    end
    e = f_mem(st, f3, a, rs2);
    q_mem.push_back(e);
    req_valid = (rdy_dly > 0);
    req_addr  = ~a;
    for (int unsigned i = 0; i < rdy_dly; i++) begin
      @(negedge clk);
      chk("bp_valid", mem_req_valid, 1);
      chk("bp_ready_low", req_ready, 0);
      chk("bp_addr", mem_addr, e.addr);
      chk("bp_wstrb", mem_wstrb, e.strb);
      if (st) chk("bp_wdata", mem_wdata, e.wdata);
      @(posedge clk); #1;
      mem_resp_valid = (i == 0);
      mem_resp_rdata = $urandom;
    end
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    req_valid     = 1'b0;
    if (st) begin
      @(negedge clk);
      chk("st_ready_after", req_ready, 1);
      chk("st_no_wb", wb_valid, 0);
      @(posedge clk); #1;
      return;
    end
    w.rd = rd;
    w.data = f_load(f3, a, rdata);
    q_wb.push_back(w);
    for (int unsigned i = 0; i < resp_dly; i++) begin
      @(negedge clk);
      chk("wait_busy", req_ready, 0);
      @(posedge clk); #1;
    end
    mem_resp_valid = 1'b1;
    mem_resp_rdata = rdata;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = $urandom;
    @(negedge clk);
    chk("wb_latency", wb_valid, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_wstrb", mem_wstrb, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wb", {wb_valid, wb_rd, wb_data}, 0);
    chk("rst_fault", fault, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(0, 3'b010, 32'h100, 0, 5'd5, 32'hDEADBEEF, 0, 0);
    run_op(0, 3'b000, 32'h103, 0, 5'd6, 32'h80123456, 0, 0);
    run_op(0, 3'b100, 32'h103, 0, 5'd7, 32'h80123456, 0, 0);
    run_op(0, 3'b001, 32'h102, 0, 5'd8, 32'h80123456, 0, 0);
    run_op(0, 3'b101, 32'h102, 0, 5'd9, 32'h80123456, 0, 0);
    run_op(1, 3'b000, 32'h201, 32'h000000AB, 5'd0, 0, 0, 0);
    run_op(1, 3'b001, 32'h202, 32'h1234CAFE, 5'd0, 0, 0, 0);
    run_op(1, 3'b010, 32'h204, 32'hA5A55A5A, 5'd0, 0, 0, 0);
    run_op(1, 3'b001, 32'h201, 32'h1111, 5'd0, 0, 0, 0);
    run_op(0, 3'b010, 32'h102, 0, 5'd3, 0, 0, 0);
    run_op(0, 3'b011, 32'h100, 0, 5'd3, 0, 0, 0);
    run_op(1, 3'b100, 32'h100, 0, 5'd0, 0, 0, 0);
    run_op(1, 3'b000, 32'h303, 32'h0000007E, 5'd0, 0, 5, 0);
    run_op(0, 3'b001, 32'h402, 0, 5'd11, 32'hFEDC8001, 5, 3);
    run_op(0, 3'b010, 32'h500, 0, 5'd0, 32'h01020304, 0, 2);

    for (int n = 0; n < 40; n++) begin
      logic [2:0] f3;
      logic       st;
      st = $urandom_range(0, 1);
      f3 = $urandom_range(0, 7);
      if ($urandom_range(0, 3) != 0) f3 = st ? 3'($urandom_range(0, 2)) : ((f3 == 3'b011 || f3 >= 3'b110) ? 3'b010 : f3);
      run_op(st, f3, $urandom, $urandom, 5'($urandom), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3));
    end

    req_valid = 1'b1; req_is_store = 1'b0; req_func3 = 3'b010;
    req_addr = 32'h600; req_rd = 5'd12;
    q_mem.push_back(f_mem(0, 3'b010, 32'h600, 0));
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_mem_req_valid", mem_req_valid, 0);
    chk("rstmid_wb_valid", wb_valid, 0);
    chk("rstmid_req_ready", req_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h55AA55AA;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstmid_no_wb", wb_valid, 0);
    end

    chk("q_mem_empty", q_mem.size(), 0);
    chk("q_wb_empty", q_wb.size(), 0);
    chk("fault_all_seen", fault_exp, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
